// File: rtl/arb_requester_if.sv
// arb_requester_if: job handshake (job_valid/job_ready/job_len), arbiter r/g pair and status (beat, busy, beats_left, done, timeout_err)
interface arb_requester_if #(parameter int LEN_W = 8);
  logic             job_valid;
  logic             job_ready;
  logic [LEN_W-1:0] job_len;
  logic             r;
  logic             g;
  logic             beat;
  logic             busy;
  logic [LEN_W-1:0] beats_left;
  logic             done;
  logic             timeout_err;
  modport master (
    input  job_valid, job_len, g,
    output job_ready, r, beat, busy, beats_left, done, timeout_err
  );
  modport slave (
    output job_valid, job_len, g,
    input  job_ready, r, beat, busy, beats_left, done, timeout_err
  );
endinterface

// File: rtl/arb_requester.sv
// arb_requester: arbiter requester agent; clk/reset plus bus (job in, r out, g in, beat/busy/beats_left/done/timeout_err status)
module arb_requester #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset,
  arb_requester_if.master bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, OWN, GAP} state_t;
  state_t           r_state, w_state_nx;
  logic             r_r, r_done, r_to;
  logic [LEN_W-1:0] r_beats;
  logic [CW-1:0]    r_wait;
  logic             w_r_nx, w_done_nx, w_to_nx, w_beat, w_last;
  logic [LEN_W-1:0] w_beats_nx;
  logic [CW-1:0]    w_wait_nx;
  assign w_beat          = r_r && bus.g && (r_state == WAIT || r_state == OWN);
  assign w_last          = r_beats == LEN_W'(1);
  assign bus.beat        = w_beat;
  assign bus.r           = r_r;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_to;
  assign bus.beats_left  = r_beats;
  assign bus.job_ready   = r_state == IDLE;
  assign bus.busy        = r_state != IDLE;
  always_comb begin
    w_state_nx = r_state;
    w_r_nx     = r_r;
    w_done_nx  = 1'b0;
    w_to_nx    = 1'b0;
    w_beats_nx = r_beats;
    w_wait_nx  = r_wait;
    case (r_state)
      IDLE: if (bus.job_valid) begin
        w_beats_nx = bus.job_len;
        w_wait_nx  = '0;
        w_r_nx     = |bus.job_len;
        w_done_nx  = ~|bus.job_len;
        w_state_nx = |bus.job_len ? WAIT : GAP;
      end
      WAIT, OWN: if (w_beat) begin
        w_beats_nx = r_beats != '0 ? r_beats - LEN_W'(1) : r_beats;
        w_r_nx     = !w_last;
        w_done_nx  = w_last;
        w_state_nx = w_last ? GAP : OWN;
      end else if (r_state == OWN) begin
        w_wait_nx  = '0;
        w_state_nx = WAIT;
      end else if (r_wait == CW'(TIMEOUT - 1)) begin
        w_r_nx     = 1'b0;
        w_to_nx    = 1'b1;
        w_state_nx = GAP;
      end else begin
        w_wait_nx = r_wait + CW'(1);
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_r     <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_beats <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_r     <= w_r_nx;
      r_done  <= w_done_nx;
      r_to    <= w_to_nx;
      r_beats <= w_beats_nx;
      r_wait  <= w_wait_nx;
    end
  end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed vectors for arb_requester checked by a per-cycle scoreboard
module tb_arb_requester;
  typedef struct {
    string       name;
    logic [13:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  arb_requester_if #(.LEN_W(8)) bus();
  arb_requester #(.LEN_W(8), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [13:0] act;
      e = q.pop_front();
      act = {bus.r, bus.beat, bus.done, bus.timeout_err, bus.busy, bus.job_ready, bus.beats_left};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got r/beat/done/to/busy/ready=%b beats_left=%0d, want %b beats_left=%0d",
                 e.name, act[13:8], act[7:0], e.v[13:8], e.v[7:0]);
      end
    end
  end
  task automatic cyc(input string name, input logic rst, input logic jv, input logic [7:0] jl,
                     input logic g, input logic [5:0] flags, input logic [7:0] bl);
    exp_t e;
    reset = rst;
    bus.job_valid = jv;
    bus.job_len = jl;
    bus.g = g;
    e.name = name;
    e.v = {flags, bl};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  localparam logic [5:0] IDL = 6'b000001;
  localparam logic [5:0] REQ = 6'b100010;
  localparam logic [5:0] BT  = 6'b110010;
  localparam logic [5:0] DN  = 6'b001010;
  localparam logic [5:0] TO  = 6'b000110;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    bus.job_valid = 1'b1;
    bus.job_len = 8'd5;
    bus.g = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 1, 1, 5, 1, IDL, 0);
    cyc("reset_release", 0, 0, 0, 0, IDL, 0);
    cyc("s_accept", 0, 1, 3, 0, IDL, 0);
    cyc("s_beat3", 0, 0, 0, 1, BT, 3);
    cyc("s_beat2", 0, 0, 0, 1, BT, 2);
    cyc("s_beat1", 0, 0, 0, 1, BT, 1);
    cyc("s_gap", 0, 0, 0, 1, DN, 0);
    cyc("s_idle", 0, 0, 0, 0, IDL, 0);
    cyc("p_accept", 0, 1, 4, 0, IDL, 0);
    cyc("p_g1", 0, 0, 0, 1, BT, 4);
    cyc("p_g2", 0, 0, 0, 1, BT, 3);
    cyc("p_pre1", 0, 0, 0, 0, REQ, 2);
    cyc("p_pre2", 0, 0, 0, 0, REQ, 2);
    cyc("p_pre3", 0, 0, 0, 0, REQ, 2);
    cyc("p_g6", 0, 0, 0, 1, BT, 2);
    cyc("p_g7", 0, 0, 0, 1, BT, 1);
    cyc("p_gap", 0, 0, 0, 0, DN, 0);
    cyc("p_idle", 0, 0, 0, 0, IDL, 0);
    cyc("t_accept", 0, 1, 5, 0, IDL, 0);
    for (int i = 0; i < 16; i++) cyc($sformatf("t_wait%0d", i), 0, 0, 0, 0, REQ, 5);
    cyc("t_gap", 0, 0, 0, 0, TO, 5);
    cyc("t_idle", 0, 0, 0, 0, IDL, 5);
    cyc("z_accept", 0, 1, 0, 0, IDL, 5);
    cyc("z_gap", 0, 0, 0, 1, DN, 0);
    cyc("z_idle", 0, 0, 0, 0, IDL, 0);
    cyc("b_accept", 0, 1, 2, 0, IDL, 0);
    cyc("b_ignore1", 0, 1, 7, 0, REQ, 2);
    cyc("b_beat2", 0, 1, 7, 1, BT, 2);
    cyc("b_beat1", 0, 1, 7, 1, BT, 1);
    cyc("b_gap", 0, 1, 7, 0, DN, 0);
    cyc("b_idle", 0, 0, 0, 0, IDL, 0);
    cyc("r_accept", 0, 1, 6, 0, IDL, 0);
    cyc("r_beat6", 0, 0, 0, 1, BT, 6);
    cyc("r_beat5", 0, 0, 0, 1, BT, 5);
    cyc("r_reset", 1, 0, 0, 1, BT, 4);
    cyc("r_after", 0, 0, 0, 1, IDL, 0);
    cyc("r_stray", 0, 0, 0, 1, IDL, 0);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for the 3-way priority arbiter: the other end of the r/g request/grant interface.
- Accepts a transfer job (beat count) from local logic, raises its request line, and counts granted beats.
- Drops the request after the last beat, or after a grant timeout.
- One instance per requester; its r output feeds one bit of the arbiter's r[3:1], and the matching g bit returns.

Parameters:
- LEN_W, 8, width of job_len and of the remaining-beat counter.
- TIMEOUT, 16, max consecutive ungranted request cycles before abort; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- job_valid  input  1  job offered
- job_ready  output  1  high only in IDLE; job accepted on clock edge with job_valid && job_ready
- job_len  input  LEN_W  beats to transfer, sampled on accept
- r  output  1  request to arbiter (registered)
- g  input  1  grant from arbiter
- beat  output  1  combinational: r && g && state in {WAIT, OWN}; one granted transfer this cycle
- busy  output  1  state != IDLE
- beats_left  output  LEN_W  remaining-beat counter
- done  output  1  one-cycle pulse: job completed
- timeout_err  output  1  one-cycle pulse: job aborted, no grant

Behaviour:
- Reset, sampled each edge:
  - state=IDLE; r=0, done=0, timeout_err=0, beats_left=0, wait counter=0.
  - Hence job_ready=1 and busy=0 after the reset edge.
  - Reset mid-job aborts silently: no done, no timeout_err; r low on the next edge.
- States: IDLE, WAIT, OWN, GAP.
- IDLE:
  - Accept with job_len>0: beats_left=job_len, r=1, wait counter=0 -> WAIT.
  - Accept with job_len==0: r stays 0 -> GAP with done=1 (zero-length job completes in 1 cycle, never requests).
- WAIT (r=1):
  - g=1: beat=1, beats_left decrements.
    - If beats_left was 1: r=0, done=1 -> GAP.
    - Else -> OWN.
  - g=0: wait counter increments.
    - On the cycle the counter equals TIMEOUT-1 with g=0: r=0, timeout_err=1, beats_left kept -> GAP.
    - So r is high for exactly TIMEOUT ungranted cycles.
- OWN (r=1):
  - g=1: beat=1, beats_left decrements.
    - If beats_left was 1: r=0, done=1 -> GAP.
  - g=0 (preempted): beat=0, wait counter cleared -> WAIT. r stays high and beats_left is kept.
- GAP:
  - r=0 for exactly 1 cycle, giving the arbiter a mandatory release cycle.
  - done and timeout_err are high only during this cycle.
  - -> IDLE.
- g while r=0 (IDLE, GAP): ignored; beat=0.
- job_valid while busy: ignored, no accept; job_len not sampled.
- done and timeout_err are never high together.
- beats_left: no wrap; it never decrements below 0.
- Wait counter width: clog2(TIMEOUT)+1.
- Latency: r rises 1 edge after accept. The first beat can occur in the first cycle r is high.

Test Plan:
- Reset: assert reset 2 cycles with job_valid=1 -> r=0, done=0, timeout_err=0, busy=0, beats_left=0; job_ready=1 after release.
- Straight grant: job_len=3, g=1 from first r cycle -> beat high 3 consecutive cycles; beats_left 3->2->1->0; r low and done=1 next cycle (GAP); job_ready=1 the cycle after.
- Preemption: job_len=4, g pattern 1,1,0,0,0,1,1 -> exactly 4 beats; r continuously high; no timeout; done after 7th r-cycle.
- Timeout: TIMEOUT=16, job_len=5, g=0 always -> r high exactly 16 cycles, then r=0 with timeout_err=1 for 1 cycle; beats_left=5; IDLE next.
- Zero length and busy: job_len=0 -> r never rises, done=1 one cycle after accept. A second job_valid during a 2-beat job -> not accepted; job_ready=0 until IDLE.
- Reset mid-OWN: job_len=6, g=1, assert reset after 2 beats -> r=0, beats_left=0 on next edge; no done/timeout_err; stray g ignored.
